// File: rtl/fetch_unit_pq.sv
// fetch_unit_pq: PC generator and prefetch queue feeding decode from a latency-1 instruction ROM.
// Optional build macro FETCH_PERF_EN adds saturating fetch_cnt / flush_cnt counters.
`default_nettype none

module fetch_unit_pq #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 9,
  parameter int DEPTH   = 4,
  parameter int BR_REL  = 0
) (
  input  logic               f_clk,
  input  logic               start,
  input  logic [PC_W-1:0]    start_addr,
  input  logic               branch,
  input  logic               taken,
  input  logic [PC_W-1:0]    target,
  input  logic [PC_W-1:0]    branch_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  input  logic               instr_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        fetch_cnt,
  output logic [15:0]        flush_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [PC_W-1:0]    fpc;
  logic               boot;
  logic               inflight;
  logic [PC_W-1:0]    inflight_pc;
  logic [INSTR_W-1:0] q_instr [DEPTH];
  logic [PC_W-1:0]    q_pc    [DEPTH];
  logic [AW-1:0]      head;
  logic [AW-1:0]      tail;
  logic [AW:0]        count;

  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               credit;
  logic               q_nonempty;
  logic               pop;
  logic               pop_q;
  logic               push;

  assign redirect    = branch & taken;
  assign redirect_pc = (BR_REL != 0) ? (branch_pc + target) : target;

  // In-flight request holds a credit so the queue can always absorb its response.
  assign credit   = (count + {{AW{1'b0}}, inflight}) < (AW+1)'(DEPTH);
  assign imem_req = ~start & ~redirect & ~boot & credit;
  assign imem_addr = fpc;

  // When the queue is empty the arriving ROM word is presented directly to decode.
  assign q_nonempty  = (count != '0);
  assign instr_valid = q_nonempty | inflight;
  assign instr_o     = q_nonempty ? q_instr[head] : (inflight ? imem_data : '0);
  assign pc_o        = q_nonempty ? q_pc[head]    : (inflight ? inflight_pc : '0);

  assign pop   = instr_valid & instr_ready;
  assign pop_q = pop & q_nonempty;
  assign push  = inflight & ~(pop & ~q_nonempty);

  always_ff @(posedge f_clk) begin
    if (start) begin
      fpc         <= start_addr;
      boot        <= 1'b1;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (redirect) begin
      fpc      <= redirect_pc;
      boot     <= 1'b0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      boot     <= 1'b0;
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fpc;
        fpc         <= fpc + PC_W'(1);
      end
      if (push) tail <= tail + AW'(1);
      if (pop_q) head <= head + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop_q};
    end
  end

  // Entries beyond count are unreachable after a flush, so storage needs no reset.
  always_ff @(posedge f_clk) begin
    if (push) begin
      q_instr[tail] <= imem_data;
      q_pc[tail]    <= inflight_pc;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge f_clk) begin
    if (start) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else if (redirect) begin
      if (flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end else if (pop && fetch_cnt != 16'hFFFF) begin
      fetch_cnt <= fetch_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit_pq.sv
// Bench for fetch_unit_pq: an absolute-target and a relative-target instance checked against a PC-queue model.
`timescale 1ns/1ps

module tb_fetch_unit_pq;

  localparam int DEPTH = 4;

  logic f_clk = 1'b0;
  always #5 f_clk = ~f_clk;

  logic       start = 1'b1;
  logic       branch = 1'b0;
  logic       taken = 1'b0;
  logic       instr_ready = 1'b0;
  logic [7:0] start_addr = 8'h00;
  logic [7:0] target = 8'h00;
  logic [7:0] branch_pc = 8'h00;

  logic       req  [2];
  logic [7:0] addr [2];
  logic [8:0] data [2] = '{9'h000, 9'h000};
  logic       val  [2];
  logic [8:0] ins  [2];
  logic [7:0] pc   [2];

  fetch_unit_pq #(.PC_W(8), .INSTR_W(9), .DEPTH(DEPTH), .BR_REL(0)) dut_abs (
    .f_clk(f_clk), .start(start), .start_addr(start_addr), .branch(branch), .taken(taken),
    .target(target), .branch_pc(branch_pc), .imem_req(req[0]), .imem_addr(addr[0]),
    .imem_data(data[0]), .instr_valid(val[0]), .instr_o(ins[0]), .pc_o(pc[0]),
    .instr_ready(instr_ready)
  );

  fetch_unit_pq #(.PC_W(8), .INSTR_W(9), .DEPTH(DEPTH), .BR_REL(1)) dut_rel (
    .f_clk(f_clk), .start(start), .start_addr(start_addr), .branch(branch), .taken(taken),
    .target(target), .branch_pc(branch_pc), .imem_req(req[1]), .imem_addr(addr[1]),
    .imem_data(data[1]), .instr_valid(val[1]), .instr_o(ins[1]), .pc_o(pc[1]),
    .instr_ready(instr_ready)
  );

  function automatic logic [8:0] rom(input logic [7:0] a);
    return 9'h100 + {1'b0, a};
  endfunction

  // Synchronous ROM per instance: word appears the cycle after the strobe.
  always @(posedge f_clk) begin
    for (int k = 0; k < 2; k++)
      if (req[k]) data[k] <= rom(addr[k]);
  end

  // Reference: fetch PC, post-reset bubble, and the ordered PCs issued but not yet consumed.
  logic [7:0] m_fpc  [2];
  bit         m_boot [2];
  logic [7:0] mq0 [$];
  logic [7:0] mq1 [$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic model_step(input int k);
    logic [7:0] q [$];
    bit ev, erq, redir;
    if (k == 0) q = mq0; else q = mq1;
    ev    = (q.size() > 0);
    redir = branch && taken;
    erq   = !start && !redir && !m_boot[k] && (q.size() < DEPTH);
    chk("instr_valid", k, {31'd0, val[k]}, {31'd0, ev});
    chk("pc_o", k, {24'd0, pc[k]}, ev ? {24'd0, q[0]} : 32'd0);
    chk("instr_o", k, {23'd0, ins[k]}, ev ? {23'd0, rom(q[0])} : 32'd0);
    chk("imem_req", k, {31'd0, req[k]}, {31'd0, erq});
    if (erq) chk("imem_addr", k, {24'd0, addr[k]}, {24'd0, m_fpc[k]});
    if (start) begin
      q.delete();
      m_fpc[k]  = start_addr;
      m_boot[k] = 1'b1;
    end else if (redir) begin
      q.delete();
      m_fpc[k]  = (k == 0) ? target : 8'(branch_pc + target);
      m_boot[k] = 1'b0;
    end else begin
      m_boot[k] = 1'b0;
      if (ev && instr_ready) void'(q.pop_front());
      if (erq) begin
        q.push_back(m_fpc[k]);
        m_fpc[k] = m_fpc[k] + 8'd1;
      end
    end
    if (k == 0) mq0 = q; else mq1 = q;
  endtask

  task automatic sample();
    @(negedge f_clk);
    for (int k = 0; k < 2; k++) model_step(k);
  endtask

  task automatic tick();
    @(posedge f_clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] a, input logic rdy);
    start = 1'b1; start_addr = a; instr_ready = rdy; branch = 1'b0; taken = 1'b0;
    sample();
    tick();
    start = 1'b0;
  endtask

  int npulse;
  logic [7:0] w;

  initial begin
    // First edge resets both instances; model starts from the reset state.
    tick();
    for (int k = 0; k < 2; k++) begin
      m_fpc[k] = 8'h00;
      m_boot[k] = 1'b1;
    end
    sample();
    chk("rst_valid", 0, {31'd0, val[0]}, 32'd0);
    chk("rst_pc", 0, {24'd0, pc[0]}, 32'd0);
    chk("rst_instr", 0, {23'd0, ins[0]}, 32'd0);
    tick();

    // Boot from 0x00 with decode always ready
    do_start(8'h00, 1'b1);
    sample(); chk("boot_bubble", 0, {31'd0, req[0]}, 32'd0); tick();
    sample(); chk("boot_req", 0, {31'd0, req[0]}, 32'd1); chk("boot_addr", 0, {24'd0, addr[0]}, 32'd0); tick();
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("boot_pc", 0, {24'd0, pc[0]}, i);
      chk("boot_instr", 0, {23'd0, ins[0]}, 32'h100 + i);
      tick();
    end

    // Backpressure: exactly DEPTH requests, then in-order drain
    do_start(8'h00, 1'b0);
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (req[0]) npulse++;
      tick();
    end
    sample();
    chk("bp_pulses", 0, npulse, DEPTH);
    chk("bp_req_idle", 0, {31'd0, req[0]}, 32'd0);
    tick();
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample();
      chk("bp_drain_valid", 0, {31'd0, val[0]}, 32'd1);
      chk("bp_drain_pc", 0, {24'd0, pc[0]}, i);
      tick();
    end

    // Absolute redirect while pc_o = 0x02
    do_start(8'h00, 1'b1);
    repeat (4) begin sample(); tick(); end
    branch = 1'b1; taken = 1'b1; target = 8'h05; branch_pc = 8'h10;
    sample(); chk("br_pc_before", 0, {24'd0, pc[0]}, 32'h02); chk("br_req_gated", 0, {31'd0, req[0]}, 32'd0); tick();
    branch = 1'b0; taken = 1'b0;
    sample(); chk("br_addr", 0, {24'd0, addr[0]}, 32'h05); chk("br_flushed", 0, {31'd0, val[0]}, 32'd0); tick();
    sample(); chk("br_pc", 0, {24'd0, pc[0]}, 32'h05); chk("br_rel_pc", 1, {24'd0, pc[1]}, 32'h15); tick();

    // Relative redirect: 0x10 + (-4) = 0x0C
    branch = 1'b1; taken = 1'b1; branch_pc = 8'h10; target = 8'hFC;
    sample(); tick();
    branch = 1'b0; taken = 1'b0;
    sample(); chk("rel_addr", 1, {24'd0, addr[1]}, 32'h0C); tick();
    sample(); chk("rel_pc", 1, {24'd0, pc[1]}, 32'h0C); chk("abs_pc", 0, {24'd0, pc[0]}, 32'hFC); tick();
    target = 8'h33;
    for (int i = 1; i <= 4; i++) begin
      branch = i[0]; taken = ~i[0];
      sample(); chk("nt_pc", 1, {24'd0, pc[1]}, 32'h0C + i); tick();
    end
    branch = 1'b0; taken = 1'b0;

    // PC wrap
    do_start(8'hFE, 1'b1);
    repeat (2) begin sample(); tick(); end
    for (int i = 0; i < 4; i++) begin
      w = 8'hFE + 8'(i);
      sample(); chk("wrap_pc", 0, {24'd0, pc[0]}, {24'd0, w}); tick();
    end

    // Reset with three queued words and one response arriving
    do_start(8'h00, 1'b0);
    repeat (5) begin sample(); tick(); end
    start = 1'b1; start_addr = 8'h40; instr_ready = 1'b1;
    sample(); chk("mr_busy", 0, {31'd0, val[0]}, 32'd1); tick();
    start = 1'b0;
    sample(); chk("mr_valid_drop", 0, {31'd0, val[0]}, 32'd0); tick();
    sample(); tick();
    sample(); chk("mr_first_pc", 0, {24'd0, pc[0]}, 32'h40); chk("mr_first_instr", 0, {23'd0, ins[0]}, 32'h140); tick();

    // Randomised traffic against the model
    for (int n = 0; n < 500; n++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      branch      = ($urandom_range(0, 9) == 0);
      taken       = ($urandom_range(0, 1) == 1);
      target      = 8'($urandom);
      branch_pc   = 8'($urandom);
      start       = ($urandom_range(0, 59) == 0);
      start_addr  = 8'($urandom);
      sample();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
